saltos_alu: RTL and testbench
=============================

// Module: saltos_alu
// PURPOSE
//  Branch-target adder for the pipelined datapath. Adds the current PC to the
//  upstream-shifted branch offset and produces the branch destination address.
//  Sits beside the main ALU in the execute stage and feeds the PC-select mux.
//  The result is registered: one cycle of latency, qualified by a valid flag.
// PARAMETERS
//  WIDTH        32   data width of pc, ShiftLeft and ALUResult
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      synchronous, active-low reset
//  in_valid     in   1      pc/ShiftLeft are valid this cycle
//  pc           in   WIDTH  PC value (PC+4 from fetch), unsigned
//  ShiftLeft    in   WIDTH  branch offset, already sign-extended and <<2 upstream
//  ALUResult    out  WIDTH  registered branch target = pc + ShiftLeft
//  out_valid    out  1      ALUResult holds a result computed from valid inputs
//  carry        out  1      carry out of bit WIDTH-1 of the addition
//  overflow     out  1      signed overflow of the addition
// BEHAVIOUR
//  - Interface: one clock (clk); reset is synchronous and active-low (rst_n).
//  - Reset: on a rising clk edge with rst_n=0:
//    ALUResult=0, out_valid=0, carry=0, overflow=0.
//  - Reset has priority over in_valid.
//  - Operation: on each rising edge with rst_n=1 and in_valid=1, register:
//    ALUResult = (pc + ShiftLeft) mod 2^WIDTH;
//    carry     = bit WIDTH of the zero-extended (WIDTH+1)-bit sum;
//    overflow  = (pc[MSB]==ShiftLeft[MSB]) && (sum[MSB]!=pc[MSB]);
//    out_valid = 1.
//  - Idle: rising edge with rst_n=1 and in_valid=0:
//    out_valid=0; ALUResult, carry and overflow hold their previous values.
//  - Latency: exactly 1 cycle from input sample to output.
//  - Throughput: one result per cycle; back-to-back valid inputs produce
//    back-to-back results. There is no backpressure.
//  - No shifting is done inside the block; ShiftLeft is used as given.
//  - Wrap-around: the sum wraps modulo 2^WIDTH. carry/overflow only report it;
//    no trap or stall is raised.
//  - Reset mid-stream: a result in flight is discarded. out_valid is 0 in the
//    cycle after the reset edge.
//  - No combinational path from inputs to outputs.
//  - X on the inputs while in_valid=0 must not propagate to the outputs.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles, pc=ShiftLeft=0
//    -> ALUResult=0, out_valid=0, carry=0, overflow=0.
//  2 Basic: pc=7, ShiftLeft=7, in_valid=1
//    -> next cycle ALUResult=14 (0x0000000E), out_valid=1, carry=0, overflow=0.
//  3 Negative offset: pc=0x00000100, ShiftLeft=0xFFFFFFF0 (-16)
//    -> ALUResult=0x000000F0, carry=1, overflow=0.
//  4 Wrap/overflow: pc=0x7FFFFFFC, ShiftLeft=0x00000008
//    -> ALUResult=0x80000004, overflow=1, carry=0.
//    pc=0xFFFFFFFC, ShiftLeft=0x8 -> ALUResult=0x4, carry=1.
//  5 Streaming/hold: 3 back-to-back valid pairs -> 3 consecutive correct results.
//    Then in_valid=0 -> out_valid=0 and ALUResult holds the last value.
//  6 Reset mid-stream: rst_n=0 on the cycle after a valid input
//    -> outputs cleared, no stale result appears with out_valid=1.

Source files
------------

// File: rtl/saltos_alu.sv
// saltos_alu: registered branch-target adder for the execute stage.
// Adds the fetch PC (PC+4) to the pre-shifted, sign-extended branch offset
// and presents the destination address one cycle later with a valid flag,
// plus carry and signed-overflow indicators that only report wrap-around.
module saltos_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] ShiftLeft,
    output logic [WIDTH-1:0] ALUResult,
    output logic             out_valid,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum;
    logic             carry_next;
    logic             overflow_next;

    // Zero-extended add so the carry out of the MSB is available as bit WIDTH;
    // overflow when both operands share a sign that the sum does not keep.
    always_comb begin
        sum_ext       = {1'b0, pc} + {1'b0, ShiftLeft};
        sum           = sum_ext[WIDTH-1:0];
        carry_next    = sum_ext[WIDTH];
        overflow_next = (pc[WIDTH-1] == ShiftLeft[WIDTH-1]) &&
                        (sum[WIDTH-1] != pc[WIDTH-1]);
    end

    // Register the result only on valid inputs so idle-cycle X never reaches the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ALUResult <= '0;
            out_valid <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ALUResult <= sum;
                carry     <= carry_next;
                overflow  <= overflow_next;
            end
        end
    end

endmodule

// File: tb/tb_saltos_alu.sv
// tb_saltos_alu: directed-vector bench for the registered branch-target adder.
module tb_saltos_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] ShiftLeft;
    logic [31:0] ALUResult;
    logic        out_valid;
    logic        carry;
    logic        overflow;

    int check_count = 0;
    int pass_count  = 0;

    saltos_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .pc        (pc),
        .ShiftLeft (ShiftLeft),
        .ALUResult (ALUResult),
        .out_valid (out_valid),
        .carry     (carry),
        .overflow  (overflow)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; pc = 32'h0; ShiftLeft = 32'h0;
        step();
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h0, 1'b0, 1'b0, 1'b0})
            $display("[TB] FAIL reset: got res=%h v=%b c=%b o=%b expected res=00000000 v=0 c=0 o=0",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
    endtask

    task automatic test_basic();
        rst_n = 1'b1; in_valid = 1'b1; pc = 32'd7; ShiftLeft = 32'd7;
        #1;
        check_count++;
        if ({ALUResult, out_valid} !== {32'h0, 1'b0})
            $display("[TB] FAIL basic_no_comb_path: got res=%h v=%b expected res=00000000 v=0",
                     ALUResult, out_valid);
        else pass_count++;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h0000000E, 1'b1, 1'b0, 1'b0})
            $display("[TB] FAIL basic_7_plus_7: got res=%h v=%b c=%b o=%b expected res=0000000e v=1 c=0 o=0",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
    endtask

    task automatic test_negative_offset();
        in_valid = 1'b1; pc = 32'h00000100; ShiftLeft = 32'hFFFFFFF0;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h000000F0, 1'b1, 1'b1, 1'b0})
            $display("[TB] FAIL negative_offset: got res=%h v=%b c=%b o=%b expected res=000000f0 v=1 c=1 o=0",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
    endtask

    task automatic test_wrap();
        in_valid = 1'b1; pc = 32'h7FFFFFFC; ShiftLeft = 32'h00000008;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h80000004, 1'b1, 1'b0, 1'b1})
            $display("[TB] FAIL signed_overflow: got res=%h v=%b c=%b o=%b expected res=80000004 v=1 c=0 o=1",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
        pc = 32'hFFFFFFFC; ShiftLeft = 32'h00000008;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h00000004, 1'b1, 1'b1, 1'b0})
            $display("[TB] FAIL unsigned_wrap: got res=%h v=%b c=%b o=%b expected res=00000004 v=1 c=1 o=0",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
        pc = 32'h80000000; ShiftLeft = 32'h80000000;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h00000000, 1'b1, 1'b1, 1'b1})
            $display("[TB] FAIL neg_overflow_carry: got res=%h v=%b c=%b o=%b expected res=00000000 v=1 c=1 o=1",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; pc = 32'h00001000; ShiftLeft = 32'h00000020;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h00001020, 1'b1, 1'b0, 1'b0})
            $display("[TB] FAIL stream_0: got res=%h v=%b c=%b o=%b expected res=00001020 v=1 c=0 o=0",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
        pc = 32'h00002000; ShiftLeft = 32'hFFFFFFFC;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h00001FFC, 1'b1, 1'b1, 1'b0})
            $display("[TB] FAIL stream_1: got res=%h v=%b c=%b o=%b expected res=00001ffc v=1 c=1 o=0",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
        pc = 32'hFFFFFF00; ShiftLeft = 32'h00000200;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h00000100, 1'b1, 1'b1, 1'b0})
            $display("[TB] FAIL stream_2: got res=%h v=%b c=%b o=%b expected res=00000100 v=1 c=1 o=0",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
        in_valid = 1'b0; pc = 'x; ShiftLeft = 'x;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h00000100, 1'b0, 1'b1, 1'b0})
            $display("[TB] FAIL idle_hold: got res=%h v=%b c=%b o=%b expected res=00000100 v=0 c=1 o=0",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h00000100, 1'b0, 1'b1, 1'b0})
            $display("[TB] FAIL idle_hold_2: got res=%h v=%b c=%b o=%b expected res=00000100 v=0 c=1 o=0",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
    endtask

    task automatic test_reset_mid_stream();
        in_valid = 1'b1; pc = 32'h00000005; ShiftLeft = 32'h00000003;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h00000008, 1'b1, 1'b0, 1'b0})
            $display("[TB] FAIL pre_reset_result: got res=%h v=%b c=%b o=%b expected res=00000008 v=1 c=0 o=0",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
        rst_n = 1'b0; in_valid = 1'b1; pc = 32'hFFFFFFF0; ShiftLeft = 32'h80000020;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h0, 1'b0, 1'b0, 1'b0})
            $display("[TB] FAIL reset_priority: got res=%h v=%b c=%b o=%b expected res=00000000 v=0 c=0 o=0",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
        rst_n = 1'b1; in_valid = 1'b0; pc = 32'h0; ShiftLeft = 32'h0;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h0, 1'b0, 1'b0, 1'b0})
            $display("[TB] FAIL post_reset_idle: got res=%h v=%b c=%b o=%b expected res=00000000 v=0 c=0 o=0",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
        in_valid = 1'b1; pc = 32'h00000010; ShiftLeft = 32'h00000004;
        step();
        check_count++;
        if ({ALUResult, out_valid, carry, overflow} !== {32'h00000014, 1'b1, 1'b0, 1'b0})
            $display("[TB] FAIL post_reset_resume: got res=%h v=%b c=%b o=%b expected res=00000014 v=1 c=0 o=0",
                     ALUResult, out_valid, carry, overflow);
        else pass_count++;
        in_valid = 1'b0;
    endtask

    initial begin
        $display("[TB] starting saltos_alu bench");
        test_reset();
        test_basic();
        test_negative_offset();
        test_wrap();
        test_back_to_back();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
